// File: rtl/vga_timing_monitor.sv
// Sink-side raster checker: measures line/frame geometry of the controller's
// hsync/vsync/blank stream, locks after one clean frame, and reports per-frame
// status, sticky error flags and a visible-pixel checksum.
module vga_timing_monitor #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned HSYNC_NEG = 1,
  parameter int unsigned VSYNC_NEG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        i_clr_err,
  output logic        o_locked,
  output logic        o_frame_done,
  output logic        o_frame_ok,
  output logic [23:0] o_checksum,
  output logic [5:0]  o_err,
  output logic [7:0]  o_frames
);

  localparam logic [9:0]  HT_M1  = 10'(H_TOTAL - 1);
  localparam logic [10:0] HVIS_C = 11'(H_VISIBLE);
  localparam logic [10:0] HSYN_C = 11'(H_SYNC);
  localparam logic [10:0] VVIS_C = 11'(V_VISIBLE);
  localparam logic [10:0] VTOT_C = 11'(V_TOTAL);
  localparam logic [10:0] VSYN_C = 11'(V_SYNC);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  state_t state, state_next;

  logic        hs_act, vs_act, hs_prev, vs_prev;
  logic        hs_lead, hs_trail, vs_lead, vs_trail;
  logic [9:0]  hcnt;
  logic [10:0] hvis_cnt, hsw_cnt, vcnt, vsw_cnt, vvis_cnt;
  logic [10:0] vcnt_end, vvis_end, vsw_end;
  logic [23:0] acc, pix;
  logic        pix_vis;
  logic        frame_err, h_first, hs_skip;
  logic        meas, entry, close, h_chk;
  logic [5:0]  err_now;
  logic        ferr_total;

  function automatic logic [10:0] inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign hs_act   = (HSYNC_NEG != 0) ? ~hsync : hsync;
  assign vs_act   = (VSYNC_NEG != 0) ? ~vsync : vsync;
  assign hs_lead  = hs_act & ~hs_prev;
  assign hs_trail = ~hs_act & hs_prev;
  assign vs_lead  = vs_act & ~vs_prev;
  assign vs_trail = ~vs_act & vs_prev;
  assign pix      = {r, g, b};
  assign pix_vis  = ~hblank & ~vblank;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEEK;
    else        state <= state_next;
  end

  // Next-state: lock on a clean frame, fall back to MEASURE on a bad one
  always_comb begin
    state_next = state;
    case (state)
      SEEK:    if (vs_lead) state_next = MEASURE;
      MEASURE: if (vs_lead && !ferr_total) state_next = LOCKED;
      LOCKED:  if (vs_lead && ferr_total) state_next = MEASURE;
      default: state_next = SEEK;
    endcase
  end

  // FSM decode: checks active, entry into measurement, frame close
  always_comb begin
    meas  = (state != SEEK);
    entry = (state == SEEK) && vs_lead;
    close = meas && vs_lead;
  end

  // Geometry checks evaluated this cycle; an hs lead coinciding with the vs
  // lead is folded into the ending frame's line counts before comparing.
  always_comb begin
    err_now    = '0;
    h_chk      = meas && hs_lead && !h_first;
    vcnt_end   = hs_lead ? inc11(vcnt) : vcnt;
    vvis_end   = (hs_lead && !vblank) ? inc11(vvis_cnt) : vvis_cnt;
    vsw_end    = hs_lead ? inc11(vsw_cnt) : vsw_cnt;
    err_now[0] = h_chk && (hcnt != HT_M1);
    err_now[1] = meas && hs_trail && !hs_skip && (hsw_cnt != HSYN_C);
    err_now[2] = h_chk && (hvis_cnt != HVIS_C);
    err_now[3] = close && (vcnt_end != VTOT_C);
    err_now[4] = meas && vs_trail && (vsw_end != VSYN_C);
    err_now[5] = close && (vvis_end != VVIS_C);
    ferr_total = frame_err || (|err_now);
  end

  // Edge history and raster counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      hcnt     <= '0;
      hvis_cnt <= '0;
      hsw_cnt  <= '0;
      vcnt     <= '0;
      vsw_cnt  <= '0;
      vvis_cnt <= '0;
      acc      <= '0;
    end else begin
      hs_prev <= hs_act;
      vs_prev <= vs_act;

      if (hs_lead)              hcnt <= '0;
      else if (hcnt != 10'h3FF) hcnt <= hcnt + 10'd1;

      if (hs_lead)      hvis_cnt <= {10'd0, ~hblank};
      else if (!hblank) hvis_cnt <= inc11(hvis_cnt);

      if (hs_lead)     hsw_cnt <= 11'd1;
      else if (hs_act) hsw_cnt <= inc11(hsw_cnt);

      if (vs_lead)      vcnt <= '0;
      else if (hs_lead) vcnt <= inc11(vcnt);

      if (vs_lead)                               vsw_cnt <= '0;
      else if (hs_lead && (vs_act || vs_trail))  vsw_cnt <= inc11(vsw_cnt);

      if (vs_lead)                 vvis_cnt <= '0;
      else if (hs_lead && !vblank) vvis_cnt <= inc11(vvis_cnt);

      if (vs_lead)      acc <= pix_vis ? pix : '0;
      else if (pix_vis) acc <= acc + pix;
    end
  end

  // Per-frame error state and the skip flags armed on entry from SEEK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      h_first   <= 1'b0;
      hs_skip   <= 1'b0;
    end else begin
      frame_err <= vs_lead ? 1'b0 : ferr_total;

      if (entry)                h_first <= 1'b1;
      else if (meas && hs_lead) h_first <= 1'b0;

      if (entry)         hs_skip <= hs_act;
      else if (hs_trail) hs_skip <= 1'b0;
    end
  end

  // Sticky error flags and frame-close results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err        <= '0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
      o_checksum   <= '0;
      o_frames     <= '0;
      o_locked     <= 1'b0;
    end else begin
      o_err        <= i_clr_err ? err_now : (o_err | err_now);
      o_frame_done <= close;
      o_locked     <= (state_next == LOCKED);
      if (close) begin
        o_frame_ok <= ~ferr_total;
        o_checksum <= acc;
        if (!ferr_total) o_frames <= o_frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor on a reduced raster geometry. A
// second instance uses active-high sync polarity and sees inverted syncs.
module tb_vga_timing_monitor;

  localparam int HV = 16;
  localparam int HT = 24;
  localparam int HS = 4;
  localparam int VV = 10;
  localparam int VT = 14;
  localparam int VS = 2;
  localparam int HS_START = HV + 2;
  localparam int V_FIRST  = 3;

  logic clk = 1'b0;
  logic rst_n, hsync, vsync, hblank, vblank, clr;
  logic [7:0] r, g, b;
  logic hsync_p, vsync_p;

  logic        locked_a, done_a, ok_a, locked_b, done_b, ok_b;
  logic [23:0] cs_a, cs_b;
  logic [5:0]  err_a, err_b;
  logic [7:0]  frames_a, frames_b;

  assign hsync_p = ~hsync;
  assign vsync_p = ~vsync;

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC(HS),
    .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC(VS),
    .HSYNC_NEG(1), .VSYNC_NEG(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .r(r), .g(g), .b(b),
    .i_clr_err(clr), .o_locked(locked_a), .o_frame_done(done_a),
    .o_frame_ok(ok_a), .o_checksum(cs_a), .o_err(err_a), .o_frames(frames_a)
  );

  vga_timing_monitor #(
    .H_VISIBLE(HV), .H_TOTAL(HT), .H_SYNC(HS),
    .V_VISIBLE(VV), .V_TOTAL(VT), .V_SYNC(VS),
    .HSYNC_NEG(0), .VSYNC_NEG(0)
  ) u_dut_pos (
    .clk(clk), .rst_n(rst_n), .hsync(hsync_p), .vsync(vsync_p),
    .hblank(hblank), .vblank(vblank), .r(r), .g(g), .b(b),
    .i_clr_err(clr), .o_locked(locked_b), .o_frame_done(done_b),
    .o_frame_ok(ok_b), .o_checksum(cs_b), .o_err(err_b), .o_frames(frames_b)
  );

  typedef struct {
    logic        ok;
    logic [23:0] cs;
    logic [7:0]  frames;
    logic        locked;
    logic [5:0]  err;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] clr_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: 0 seek, 1 measure, 2 locked
  int          mst    = 0;
  logic [7:0]  mframes = '0;
  logic [5:0]  merr   = '0;
  logic [23:0] mcs    = '0;
  logic [5:0]  cur_fb = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked_a"}, 32'(locked_a), 0);
    check({tag, "_done_a"},   32'(done_a),   0);
    check({tag, "_ok_a"},     32'(ok_a),     0);
    check({tag, "_cs_a"},     32'(cs_a),     0);
    check({tag, "_err_a"},    32'(err_a),    0);
    check({tag, "_frames_a"}, 32'(frames_a), 0);
    check({tag, "_locked_b"}, 32'(locked_b), 0);
    check({tag, "_frames_b"}, 32'(frames_b), 0);
  endtask

  // Frame-close results are compared when the done pulse appears
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && (done_a || done_b)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done_a | done_b), 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_a",   32'(done_a),   1);
        check("done_b",   32'(done_b),   1);
        check("ok_a",     32'(ok_a),     32'(mon_e.ok));
        check("ok_b",     32'(ok_b),     32'(mon_e.ok));
        check("cs_a",     32'(cs_a),     32'(mon_e.cs));
        check("cs_b",     32'(cs_b),     32'(mon_e.cs));
        check("frames_a", 32'(frames_a), 32'(mon_e.frames));
        check("frames_b", 32'(frames_b), 32'(mon_e.frames));
        check("locked_a", 32'(locked_a), 32'(mon_e.locked));
        check("locked_b", 32'(locked_b), 32'(mon_e.locked));
        check("err_a",    32'(err_a),    32'(mon_e.err));
        check("err_b",    32'(err_b),    32'(mon_e.err));
      end
    end
  end

  // Error flags the cycle after a clear
  logic clr_d = 1'b0;
  logic [5:0] mon_c;
  always @(posedge clk) clr_d <= clr;
  always @(negedge clk) begin
    if (rst_n && clr_d) begin
      if (clr_q.size() == 0) begin
        check("unexpected_clr", 32'(clr_d), 0);
      end else begin
        mon_c = clr_q.pop_front();
        check("clr_err_a", 32'(err_a), 32'(mon_c));
        check("clr_err_b", 32'(err_b), 32'(mon_c));
      end
    end
  end

  task automatic drive_cycle(input logic hs_on, input logic vs_on, input logic hb,
                             input logic vb, input logic [23:0] pix, input logic clr_on);
    @(posedge clk);
    #1;
    hsync  = ~hs_on;
    vsync  = ~vs_on;
    hblank = hb;
    vblank = vb;
    {r, g, b} = pix;
    clr    = clr_on;
  endtask

  // Called at a vs lead: settles the frame just ended, starts tracking the next
  task automatic close_frame(input logic [5:0] fb_new);
    exp_t e;
    if (mst == 0) begin
      mst = 1;
    end else begin
      merr = merr | cur_fb;
      e.ok = (cur_fb == 6'd0);
      if (e.ok) mframes = mframes + 8'd1;
      mst = e.ok ? 2 : 1;
      e.cs     = mcs;
      e.frames = mframes;
      e.locked = (mst == 2);
      e.err    = merr;
      sb_q.push_back(e);
    end
    mcs    = '0;
    cur_fb = fb_new;
  endtask

  task automatic drive_frame(input int short_line, input int narrow_line, input int n_lines,
                             input int vs_lines, input int blank_line, input int clr_line,
                             input int rst_line, input bit const_rgb);
    logic [5:0] fb;
    fb = '0;
    if (short_line >= 0)  fb[0] = 1'b1;
    if (narrow_line >= 0) fb[1] = 1'b1;
    if (n_lines != VT)    fb[3] = 1'b1;
    if (vs_lines != VS)   fb[4] = 1'b1;
    if (blank_line >= 0)  fb[5] = 1'b1;
    for (int l = 0; l < n_lines; l++) begin
      int len;
      len = (l == short_line) ? HT - 1 : HT;
      for (int hc = 0; hc < len; hc++) begin
        logic hs_on, vs_on, hb, vb, clr_on;
        logic [23:0] pix;
        int hw;
        if (l == 0 && hc == 0) close_frame(fb);
        hw     = (l == narrow_line) ? HS - 1 : HS;
        hs_on  = (hc >= HS_START) && (hc < HS_START + hw);
        vs_on  = (l < vs_lines);
        hb     = (hc >= HV);
        vb     = !((l >= V_FIRST) && (l < V_FIRST + VV)) || (l == blank_line);
        pix    = const_rgb ? 24'h010203 : 24'($urandom);
        clr_on = (l == clr_line) && (hc == 5);
        if (!hb && !vb) mcs = mcs + pix;
        if (clr_on) begin
          clr_q.push_back(6'd0);
          merr = '0;
        end
        drive_cycle(hs_on, vs_on, hb, vb, pix, clr_on);
        if (l == rst_line && hc == 5) begin
          rst_n = 1'b0;
          #2;
          check_all_zero("midreset");
          mst     = 0;
          mframes = '0;
          merr    = '0;
          #1 rst_n = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    hsync = 1'b1; vsync = 1'b1; hblank = 1'b1; vblank = 1'b1;
    r = '0; g = '0; b = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 24'd0, 1'b0);

    //          short narrow lines   vs  blank clr  rst  const
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b1); // f0 first measured
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f1
    drive_frame( 5,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f2 short line
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f3 relock
    drive_frame(-1,    7,    VT,     VS, -1,   -1,  -1,  1'b0); // f4 narrow hsync
    drive_frame(-1,   -1,    VT,     VS, -1,    1,  -1,  1'b0); // f5 clear errors
    drive_frame(-1,   -1,    VT - 1, VS, -1,   -1,  -1,  1'b0); // f6 short frame
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f7
    drive_frame(-1,   -1,    VT,      3, -1,   -1,  -1,  1'b0); // f8 wide vsync
    drive_frame(-1,   -1,    VT,     VS,  5,   -1,  -1,  1'b0); // f9 blanked line
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f10
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f11
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,   6,  1'b0); // f12 reset mid-frame
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f13 re-entry
    check("locked_a_after_entry", 32'(locked_a), 0);
    check("locked_b_after_entry", 32'(locked_b), 0);
    drive_frame(-1,   -1,    VT,     VS, -1,   -1,  -1,  1'b0); // f14

    close_frame('0);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 24'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("sb_drain",  32'(sb_q.size()),  0);
    check("clr_drain", 32'(clr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
